fu_seq_ctrl: RTL and testbench
==============================

Name: fu_seq_ctrl

Overview:
- Sequencer for the external functional unit that the decode stage reaches through the ALU register aliases: x29 ALUOP, x30 OP1, x31 OP2, x27 OP3 read and x26 CSR read.
- Captures operand and opcode writes, launches one multi-cycle operation on the compute engine and waits for completion with a timeout.
- Returns the result on op3_o and status on csr_o, and drives busy_o, which the decode stage uses for its ALU-register stall.

Parameters:
- DBITS, 32, data width.
- OPBITS, 4, engine opcode width (taken from wr_data_i[OPBITS-1:0]).
- NUM_OPS, 10, valid opcodes are 0..NUM_OPS-1.
- TIMEOUT, 64, maximum cycles per operation, counting the ISSUE cycle; legal range 2..2^CNTBITS-1.
- CNTBITS, 16, width of the cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- wr_aluop_i  in  1  write-back to x29: launch request.
- wr_op1_i  in  1  write-back to x30.
- wr_op2_i  in  1  write-back to x31.
- wr_data_i  in  DBITS  write-back data shared by the three writes.
- rd_op3_i  in  1  store in decode is reading x27.
- op3_o  out  DBITS  last captured result.
- csr_o  out  DBITS  status word.
- busy_o  out  1  operation in flight.
- eng_start_o  out  1  one-cycle launch pulse.
- eng_op_o  out  OPBITS  engine opcode.
- eng_a_o  out  DBITS  operand A.
- eng_b_o  out  DBITS  operand B.
- eng_abort_o  out  1  one-cycle abort pulse.
- eng_done_i  in  1  engine completion strobe.
- eng_result_i  in  DBITS  engine result, valid when eng_done_i is high.

Behaviour:
- Clocking and reset: clk; reset is synchronous, active-high. All registers and outputs reset to 0, state resets to IDLE. The engine shares this reset, so no abort is issued on reset.
- States:
  - IDLE: accepts writes.
  - ISSUE: eng_start_o=1 for exactly this cycle.
  - WAIT: waits for done or timeout.
- busy_o is high exactly when state is ISSUE or WAIT. It is registered, so it rises the cycle after an accepted ALUOP write.
- Write protocol:
  - More than one of the wr_*_i strobes high in the same cycle: nothing is accepted and err_proto is set.
  - In IDLE, wr_op1_i loads A and wr_op2_i loads B from wr_data_i.
  - In IDLE, wr_aluop_i with opcode < NUM_OPS:
    - latches the opcode;
    - clears done and all error bits;
    - clears the counter;
    - goes to ISSUE next cycle.
  - In IDLE, wr_aluop_i with opcode >= NUM_OPS: err_bad_op is set, there is no launch and the state stays IDLE.
  - Any wr_*_i while busy: ignored, err_overrun is set, operands are unchanged.
- eng_op_o, eng_a_o and eng_b_o are driven from the latched registers and stay stable from ISSUE through the end of WAIT.
- Counter:
  - Increments once per cycle in ISSUE and WAIT, saturating at 2^CNTBITS-1.
  - "Elapsed" is the counter value including the current cycle: 1 in ISSUE.
- eng_done_i is sampled in ISSUE and WAIT. When it is high:
  - op3 is loaded with eng_result_i;
  - done is set;
  - last_cycles is set to elapsed;
  - the next state is IDLE.
- Timeout:
  - Applies in WAIT when eng_done_i is low and elapsed == TIMEOUT.
  - eng_abort_o pulses 1 that cycle.
  - err_timeout is set, op3 is unchanged, last_cycles is set to TIMEOUT, and the next state is IDLE.
- If done and timeout occur in the same cycle, done wins and there is no abort.
- eng_done_i in IDLE is ignored.
- rd_op3_i:
  - In IDLE, it clears done on the next edge.
  - While busy, it returns the stale op3, leaves done as is and sets err_overrun.
  - op3_o always drives the register, with no bypass.
- csr_o layout:
  - [0] busy
  - [1] done
  - [2] err_timeout
  - [3] err_bad_op
  - [4] err_overrun
  - [5] err_proto
  - [7:6] 0
  - [11:8] last opcode (zero-extended or truncated to 4 bits)
  - [15:12] 0
  - [31:16] last_cycles (low 16 bits)
- Error bits are sticky until the next accepted launch or reset.

Test Plan:
- Reset asserted 3 cycles -> busy_o=0, op3_o=0, csr_o=0, eng_start_o=0, eng_abort_o=0.
- OP1=7, OP2=6, ALUOP=2 on consecutive cycles; engine raises done with result 42 on the 6th cycle counting the ISSUE cycle -> the expected sequence is:
  - eng_start_o high exactly 1 cycle, the cycle after the ALUOP write;
  - busy_o high for 6 cycles;
  - op3_o=42;
  - csr_o=0x0006_0202.
- TIMEOUT=8, engine never done -> eng_abort_o pulses at elapsed 8, busy_o falls the cycle after, op3_o is unchanged, csr_o[2]=1, csr_o[31:16]=8.
- ALUOP=15 with NUM_OPS=10 -> no eng_start_o, busy_o stays 0, csr_o[3]=1; a following valid ALUOP clears csr_o[3].
- Write OP1=99 while busy, then rd_op3_i while busy -> eng_a_o is unchanged and csr_o[4]=1. In a separate run, done and timeout arrive in the same cycle -> result is captured and eng_abort_o stays 0.
- Assert reset during WAIT -> next cycle state is IDLE, busy_o=0, csr_o=0, eng_abort_o=0; a new launch afterwards completes normally.

Source files
------------

// File: rtl/fu_seq_ctrl.sv
// Sequencer for the external functional unit behind the ALU register aliases:
// captures operands/opcode, launches one engine operation and waits for done or timeout.
module fu_seq_ctrl #(
   parameter int DBITS   = 32,
   parameter int OPBITS  = 4,
   parameter int NUM_OPS = 10,
   parameter int TIMEOUT = 64,
   parameter int CNTBITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_aluop_i,
   input  logic               wr_op1_i,
   input  logic               wr_op2_i,
   input  logic [DBITS-1:0]   wr_data_i,
   input  logic               rd_op3_i,
   output logic [DBITS-1:0]   op3_o,
   output logic [DBITS-1:0]   csr_o,
   output logic               busy_o,
   output logic               eng_start_o,
   output logic [OPBITS-1:0]  eng_op_o,
   output logic [DBITS-1:0]   eng_a_o,
   output logic [DBITS-1:0]   eng_b_o,
   output logic               eng_abort_o,
   input  logic               eng_done_i,
   input  logic [DBITS-1:0]   eng_result_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [OPBITS:0]    LP_NUM_OPS = (OPBITS+1)'(NUM_OPS);
   localparam logic [CNTBITS-1:0] LP_TIMEOUT = CNTBITS'(TIMEOUT);
   localparam logic [CNTBITS-1:0] LP_CNT_MAX = '1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DBITS-1:0]     r_a;
   logic [DBITS-1:0]     r_b;
   logic [OPBITS-1:0]    r_op;
   logic [DBITS-1:0]     r_op3;
   logic [CNTBITS-1:0]   r_cnt;
   logic [CNTBITS-1:0]   r_last_cycles;
   logic                 r_done;
   logic                 r_err_timeout;
   logic                 r_err_bad_op;
   logic                 r_err_overrun;
   logic                 r_err_proto;

   logic                 w_busy;
   logic                 w_any_wr;
   logic                 w_multi;
   logic                 w_op_valid;
   logic [CNTBITS-1:0]   w_elapsed;
   logic                 w_launch;
   logic                 w_bad_op;
   logic                 w_done_hit;
   logic                 w_timeout;
   logic [31:0]          w_csr;

   assign w_busy     = (r_state != IDLE);
   assign w_any_wr   = wr_aluop_i | wr_op1_i | wr_op2_i;
   assign w_multi    = (wr_aluop_i & wr_op1_i) | (wr_aluop_i & wr_op2_i) | (wr_op1_i & wr_op2_i);
   assign w_op_valid = ({1'b0, wr_data_i[OPBITS-1:0]} < LP_NUM_OPS);
   // Elapsed counts the current cycle, so ISSUE sees 1 after the launch clears the counter.
   assign w_elapsed  = (r_cnt == LP_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_bad_op    = 1'b0;
      w_done_hit  = 1'b0;
      w_timeout   = 1'b0;
      eng_start_o = 1'b0;
      eng_abort_o = 1'b0;
      case (r_state)
         IDLE: begin
            if (wr_aluop_i && !w_multi) begin
               if (w_op_valid) begin
                  w_launch    = 1'b1;
                  w_state_nxt = ISSUE;
               end else begin
                  w_bad_op = 1'b1;
               end
            end
         end
         ISSUE: begin
            eng_start_o = !reset;
            if (eng_done_i) begin
               w_done_hit  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            // Done takes priority over a coincident timeout; reset suppresses the abort.
            if (eng_done_i) begin
               w_done_hit  = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_elapsed == LP_TIMEOUT) begin
               w_timeout   = 1'b1;
               eng_abort_o = !reset;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a           <= '0;
         r_b           <= '0;
         r_op          <= '0;
         r_op3         <= '0;
         r_cnt         <= '0;
         r_last_cycles <= '0;
         r_done        <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_bad_op  <= 1'b0;
         r_err_overrun <= 1'b0;
         r_err_proto   <= 1'b0;
      end else begin
         if (w_multi) r_err_proto <= 1'b1;
         if (w_busy && (w_any_wr || rd_op3_i)) r_err_overrun <= 1'b1;
         if (!w_busy && !w_multi) begin
            if (wr_op1_i) r_a <= wr_data_i;
            if (wr_op2_i) r_b <= wr_data_i;
         end
         if (!w_busy && rd_op3_i) r_done <= 1'b0;
         if (w_bad_op) r_err_bad_op <= 1'b1;
         if (w_launch) begin
            r_op          <= wr_data_i[OPBITS-1:0];
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_bad_op  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_proto   <= 1'b0;
            r_cnt         <= '0;
         end
         if (w_busy) r_cnt <= w_elapsed;
         if (w_done_hit) begin
            r_op3         <= eng_result_i;
            r_done        <= 1'b1;
            r_last_cycles <= w_elapsed;
         end
         if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_last_cycles <= LP_TIMEOUT;
         end
      end
   end

   assign w_csr = {16'(r_last_cycles), 4'b0000, 4'(r_op), 2'b00, r_err_proto, r_err_overrun,
                   r_err_bad_op, r_err_timeout, r_done, w_busy};

   assign csr_o    = DBITS'(w_csr);
   assign op3_o    = r_op3;
   assign busy_o   = w_busy;
   assign eng_op_o = r_op;
   assign eng_a_o  = r_a;
   assign eng_b_o  = r_b;

endmodule

// File: tb/tb_fu_seq_ctrl.sv
// Randomized bench for fu_seq_ctrl against a per-operation model: each launch is
// described by its engine latency, from which busy length, result, status and abort follow.
module tb_fu_seq_ctrl;

   localparam int DBITS   = 32;
   localparam int OPBITS  = 4;
   localparam int NUM_OPS = 10;
   localparam int TIMEOUT = 8;
   localparam int CNTBITS = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_aluop_i, wr_op1_i, wr_op2_i, rd_op3_i;
   logic [DBITS-1:0]  wr_data_i;
   logic [DBITS-1:0]  op3_o, csr_o, eng_a_o, eng_b_o, eng_result_i;
   logic              busy_o, eng_start_o, eng_abort_o, eng_done_i;
   logic [OPBITS-1:0] eng_op_o;

   always #5 clk = ~clk;

   fu_seq_ctrl #(
      .DBITS(DBITS), .OPBITS(OPBITS), .NUM_OPS(NUM_OPS), .TIMEOUT(TIMEOUT), .CNTBITS(CNTBITS)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_aluop_i(wr_aluop_i), .wr_op1_i(wr_op1_i), .wr_op2_i(wr_op2_i),
      .wr_data_i(wr_data_i), .rd_op3_i(rd_op3_i),
      .op3_o(op3_o), .csr_o(csr_o), .busy_o(busy_o),
      .eng_start_o(eng_start_o), .eng_op_o(eng_op_o), .eng_a_o(eng_a_o), .eng_b_o(eng_b_o),
      .eng_abort_o(eng_abort_o), .eng_done_i(eng_done_i), .eng_result_i(eng_result_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Architectural view of the unit between operations
   logic [31:0] m_a, m_b, m_op3;
   logic [3:0]  m_op;
   logic        m_done, m_to, m_bad, m_ovr, m_proto;
   int          m_last;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_csr(input logic busy);
      return {16'(m_last), 4'b0000, m_op, 2'b00, m_proto, m_ovr, m_bad, m_to, m_done, busy};
   endfunction

   task automatic model_reset();
      m_a = '0; m_b = '0; m_op3 = '0; m_op = '0; m_last = 0;
      m_done = 0; m_to = 0; m_bad = 0; m_ovr = 0; m_proto = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      wr_aluop_i = 0; wr_op1_i = 0; wr_op2_i = 0; rd_op3_i = 0;
      eng_done_i = 0; wr_data_i = '0; eng_result_i = '0;
   endtask

   task automatic chk_idle(input string tag);
      check_val({tag, "_busy"},  busy_o, 0);
      check_val({tag, "_start"}, eng_start_o, 0);
      check_val({tag, "_abort"}, eng_abort_o, 0);
      check_val({tag, "_op3"},   op3_o, m_op3);
      check_val({tag, "_csr"},   csr_o, exp_csr(1'b0));
      check_val({tag, "_a"},     eng_a_o, m_a);
      check_val({tag, "_b"},     eng_b_o, m_b);
      check_val({tag, "_op"},    eng_op_o, m_op);
   endtask

   task automatic wr_operand(input int which, input logic [31:0] d);
      wr_op1_i = (which == 1);
      wr_op2_i = (which == 2);
      wr_data_i = d;
      tick();
      clr_inputs();
      if (which == 1) m_a = d; else m_b = d;
   endtask

   task automatic wr_aluop(input logic [31:0] d);
      wr_aluop_i = 1;
      wr_data_i  = d;
      #1;
      check_val("aluop_cyc_start", eng_start_o, 0);
      check_val("aluop_cyc_busy",  busy_o, 0);
      tick();
      clr_inputs();
   endtask

   // Operation whose engine reports done at elapsed cycle 'lat' (lat > TIMEOUT: never).
   // wr_k/rd_k: elapsed cycle at which an OP1 write / OP3 read is attempted (0 = none).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] opw,
                         input int lat, input logic [31:0] res, input int wr_k, input int rd_k);
      int endk;
      wr_operand(1, a);
      wr_operand(2, b);
      wr_aluop(opw);
      m_op = opw[3:0];
      m_done = 0; m_to = 0; m_bad = 0; m_ovr = 0; m_proto = 0;
      endk = (lat <= TIMEOUT) ? lat : TIMEOUT;
      for (int k = 1; k <= endk; k++) begin
         eng_done_i   = (k == lat);
         eng_result_i = (k == lat) ? res : $urandom;
         wr_op1_i     = (k == wr_k);
         wr_data_i    = (k == wr_k) ? 32'd99 : '0;
         rd_op3_i     = (k == rd_k);
         #1;
         check_val("op_busy",  busy_o, 1);
         check_val("op_start", eng_start_o, (k == 1));
         check_val("op_abort", eng_abort_o, (k == TIMEOUT) && (lat > TIMEOUT));
         check_val("op_a",     eng_a_o, m_a);
         check_val("op_b",     eng_b_o, m_b);
         check_val("op_code",  eng_op_o, m_op);
         check_val("op_stale", op3_o, m_op3);
         tick();
         clr_inputs();
      end
      if ((wr_k >= 1 && wr_k <= endk) || (rd_k >= 1 && rd_k <= endk)) m_ovr = 1;
      if (lat <= TIMEOUT) begin
         m_op3 = res; m_done = 1; m_last = lat;
      end else begin
         m_to = 1; m_last = TIMEOUT;
      end
      chk_idle("post_op");
   endtask

   logic [31:0] tmp;
   int          act, sel;

   initial begin
      clr_inputs();
      model_reset();
      reset = 1;
      repeat (3) tick();
      chk_idle("reset");
      reset = 0;

      // Directed: 7, 6, opcode 2, done on 6th cycle with 42
      run_op(32'd7, 32'd6, 32'd2, 6, 32'd42, 0, 0);
      check_val("dir_csr_const", csr_o, 32'h0006_0202);
      check_val("dir_op3_const", op3_o, 32'd42);

      // Timeout: engine never completes
      run_op(32'd11, 32'd12, 32'd5, 1000, 32'hdead_beef, 0, 0);
      check_val("to_bit", csr_o[2], 1);
      check_val("to_cycles", csr_o[31:16], TIMEOUT);

      // Bad opcode then a valid launch
      wr_aluop(32'd15);
      m_bad = 1;
      chk_idle("badop");
      check_val("badop_bit", csr_o[3], 1);
      run_op(32'd1, 32'd2, 32'd9, 3, 32'h1234_5678, 0, 0);
      check_val("badop_clr", csr_o[3], 0);

      // Overrun: OP1=99 and an OP3 read while busy
      run_op(32'd5, 32'd6, 32'd1, 5, 32'h0bad_cafe, 3, 4);
      check_val("ovr_bit", csr_o[4], 1);
      check_val("ovr_a", eng_a_o, 32'd5);

      // Done coincides with timeout
      run_op(32'd3, 32'd4, 32'd7, TIMEOUT, 32'h5555_aaaa, 0, 0);
      check_val("tie_to_bit", csr_o[2], 0);

      // Reset in WAIT exactly when the timeout would fire
      wr_operand(1, 32'd21);
      wr_operand(2, 32'd22);
      wr_aluop(32'd3);
      for (int k = 1; k < TIMEOUT; k++) tick();
      reset = 1;
      #1;
      check_val("rst_wait_abort", eng_abort_o, 0);
      tick();
      reset = 0;
      model_reset();
      chk_idle("rst_wait");
      run_op(32'd8, 32'd9, 32'd4, 2, 32'h0000_0077, 0, 0);

      for (int it = 0; it < 60; it++) begin
         act = $urandom_range(0, 5);
         if (act <= 2) begin
            tmp = $urandom;
            tmp[3:0] = 4'($urandom_range(0, NUM_OPS - 1));
            run_op($urandom, $urandom, tmp, $urandom_range(1, TIMEOUT + 3), $urandom,
                   $urandom_range(0, 12), $urandom_range(0, 12));
         end else if (act == 3) begin
            tmp = $urandom;
            tmp[3:0] = 4'($urandom_range(NUM_OPS, 15));
            wr_aluop(tmp);
            m_bad = 1;
            chk_idle("rnd_badop");
         end else if (act == 4) begin
            sel = $urandom_range(0, 3);
            wr_aluop_i = (sel != 0);
            wr_op1_i   = (sel != 1);
            wr_op2_i   = (sel != 2);
            wr_data_i  = $urandom;
            tick();
            clr_inputs();
            m_proto = 1;
            chk_idle("rnd_proto");
         end else begin
            sel = $urandom_range(1, 3);
            rd_op3_i     = sel[0];
            eng_done_i   = sel[1];
            eng_result_i = $urandom;
            tick();
            clr_inputs();
            if (sel[0]) m_done = 0;
            chk_idle("rnd_idle");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
